// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with one-hot grant decode.
// Holds a grant until done, withdrawal or HOLD_MAX timeout.
module rr_decode_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int GAP      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  localparam bit TO_EN = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST =
    8'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [3:0] GAP_LOAD =
    4'((GAP == 0) ? 0 : GAP - 1);

  state_t     state, state_n;
  logic [7:0] hold_cnt, hold_n;
  logic [3:0] gap_cnt, gap_n;
  logic [2:0] last_idx, last_n;
  logic [7:0] gnt_n;
  logic [2:0] idx_n;
  logic       valid_n;
  logic       to_n;
  logic       busy_n;
  logic [2:0] pick_idx;
  logic       pick_ok;
  logic [2:0] cand;
  logic       rel_user;
  logic       rel_to;

  // Search req starting just after the last grantee, wrapping 7 to 0.
  always_comb begin
    pick_idx = 3'd0;
    pick_ok  = 1'b0;
    cand     = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_idx + 3'(k);
      if (!pick_ok && req[cand]) begin
        pick_idx = cand;
        pick_ok  = 1'b1;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    gap_n    = gap_cnt;
    last_n   = last_idx;
    gnt_n    = gnt;
    idx_n    = gnt_idx;
    valid_n  = gnt_valid;
    to_n     = 1'b0;
    rel_user = done | ~req[gnt_idx];
    rel_to   = TO_EN && (hold_cnt == HOLD_LAST);
    unique case (state)
      S_IDLE: begin
        if (pick_ok) begin
          gnt_n   = 8'h01 << pick_idx;
          idx_n   = pick_idx;
          valid_n = 1'b1;
          hold_n  = 8'd0;
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        if (hold_cnt != 8'hFF) begin
          hold_n = hold_cnt + 8'd1;
        end
        if (rel_user || rel_to) begin
          gnt_n   = 8'h00;
          valid_n = 1'b0;
          last_n  = gnt_idx;
          to_n    = rel_to & ~rel_user;
          if (GAP > 0) begin
            state_n = S_GAP;
            gap_n   = GAP_LOAD;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State and output registers; reset restarts rotation at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= 8'd0;
      gap_cnt   <= 4'd0;
      last_idx  <= 3'd7;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      gap_cnt   <= gap_n;
      last_idx  <= last_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      timeout   <= to_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus
// random traffic against a cycle-level ownership model.
module tb_rr_decode_arbiter;

  localparam int HOLD_MAX = 4;
  localparam int GAP      = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // model: who owns the resource, how long, and dead time left
  int m_owner = -1;
  int m_held  = 0;
  int m_wait  = 0;
  int m_last  = 7;
  int m_idx   = 0;
  bit m_to    = 1'b0;

  rr_decode_arbiter #(
    .HOLD_MAX(HOLD_MAX),
    .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] exp_gnt();
    if (m_owner >= 0) return 8'h01 << m_owner;
    return 8'h00;
  endfunction

  function automatic logic exp_busy();
    return (m_owner >= 0) || (m_wait > 0);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_wait  = 0;
    m_last  = 7;
    m_idx   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    bit user;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      user = done || !req[m_owner];
      if (user || (HOLD_MAX != 0 && m_held == HOLD_MAX)) begin
        m_to    = !user;
        m_last  = m_owner;
        m_owner = -1;
        m_wait  = GAP;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (req != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        if (req[(m_last + k) % 8]) begin
          m_owner = (m_last + k) % 8;
          break;
        end
      end
      m_idx  = m_owner;
      m_held = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req  = 8'h00;
    done = 1'b0;
    rst  = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req  = 8'h00;
    done = 1'b0;
    rst  = 1'b1;
    #3;
    checks++;
    if (gnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_gnt: got %h want 00", gnt);
    end
    checks++;
    if (gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_idx: got %0d want 0", gnt_idx);
    end
    checks++;
    if ({gnt_valid, timeout, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {gnt_valid, timeout, busy});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    int dead;
    int n;
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      dead = 0;
      n = 0;
      while (gnt_valid !== 1'b1 && n < 20) begin
        dead++;
        n++;
        tick();
      end
      checks++;
      if (n >= 20) begin
        errors++;
        $display("FAIL rot_wait: no grant %0d within 20 cycles", g);
      end
      checks++;
      if (gnt_idx !== 3'(g % 8) || gnt !== (8'h01 << (g % 8))) begin
        errors++;
        $display("FAIL rot_grant: got idx %0d gnt %h want idx %0d",
                 gnt_idx, gnt, g % 8);
      end
      checks++;
      if (gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL rot_model: got %h want %h", gnt, exp_gnt());
      end
      if (g > 0) begin
        checks++;
        if (dead != 2) begin
          errors++;
          $display("FAIL rot_dead: got %0d want 2", dead);
        end
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    req = 8'h00;
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    req = 8'h04;
    tick();
    checks++;
    if (gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL wrap_setup: got idx %0d want 2", gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h24;
    n = 0;
    while (gnt_valid !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL wrap_first: got %h idx %0d want 20 idx 5",
               gnt, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n = 0;
    while (gnt_valid !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL wrap_second: got %h idx %0d want 04 idx 2",
               gnt, gnt_idx);
    end
    req = 8'h00;
  endtask

  task automatic test_timeout();
    int vis;
    do_reset();
    req = 8'h01;
    tick();
    vis = 0;
    while (gnt === 8'h01 && vis < 20) begin
      vis++;
      tick();
    end
    checks++;
    if (vis != HOLD_MAX) begin
      errors++;
      $display("FAIL to_hold: got %0d cycles want %0d", vis, HOLD_MAX);
    end
    checks++;
    if (timeout !== 1'b1 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: got to=%b valid=%b want to=1 valid=0",
               timeout, gnt_valid);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_width: got %b want 0", timeout);
    end
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL to_regrant: got %h idx %0d want 01 idx 0",
               gnt, gnt_idx);
    end
    req = 8'h00;
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    req = 8'h01;
    for (int i = 0; i < HOLD_MAX; i++) tick();
    checks++;
    if (gnt !== 8'h01) begin
      errors++;
      $display("FAIL dto_hold: got %h want 01", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL dto_release: got to=%b valid=%b want to=0 valid=0",
               timeout, gnt_valid);
    end
    checks++;
    if (timeout !== m_to) begin
      errors++;
      $display("FAIL dto_model: got %b want %b", timeout, m_to);
    end
    req = 8'h00;
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 8'h08;
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL wd_grant: got %h idx %0d want 08 idx 3",
               gnt, gnt_idx);
    end
    tick();
    req = 8'h00;
    tick();
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_gap: got gnt %h busy %b to %b want 00 1 0",
               gnt, busy, timeout);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 8'h00 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL wd_idle: got busy %b gnt %h idx %0d want 0 00 3",
               busy, gnt, gnt_idx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h40;
    tick();
    tick();
    checks++;
    if (gnt !== 8'h40) begin
      errors++;
      $display("FAIL rm_setup: got %h want 40", gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: got gnt %h valid %b want 00 0",
               gnt, gnt_valid);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 8'hC0;
    tick();
    checks++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
      errors++;
      $display("FAIL rm_first: got %h idx %0d want 40 idx 6",
               gnt, gnt_idx);
    end
    req = 8'h00;
  endtask

  task automatic test_random();
    bit prev_to;
    do_reset();
    prev_to = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 8'($urandom) & 8'($urandom);
      end
      done = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if ({gnt, gnt_idx, gnt_valid, timeout, busy} !==
          {exp_gnt(), 3'(m_idx), m_owner >= 0, m_to, exp_busy()}) begin
        errors++;
        $display("FAIL rnd_c%0d: got %h/%0d/%b/%b/%b want %h/%0d/%b/%b/%b",
                 c, gnt, gnt_idx, gnt_valid, timeout, busy,
                 exp_gnt(), m_idx, m_owner >= 0, m_to, exp_busy());
      end
      checks++;
      if (!$onehot0(gnt) || gnt_valid !== (gnt != 8'h00) ||
          (timeout && (gnt_valid || prev_to))) begin
        errors++;
        $display("FAIL rnd_inv_c%0d: got gnt %h valid %b to %b prev %b",
                 c, gnt, gnt_valid, timeout, prev_to);
      end
      prev_to = timeout;
    end
    req  = 8'h00;
    done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_timeout();
    test_done_at_timeout();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
